// File: rtl/gouram_trace_pkg.sv
// Shared constants and helpers for the gouram multi-channel trace concentrator.
// Holds the channel-index width rule, the drop-counter width and the FIFO entry layout.
package gouram_trace_pkg;

  localparam int DROP_CNT_W = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_e;

  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A FIFO entry is {timestamp, record}: timestamp in the upper bits, record in the lower bits.
  function automatic int entry_w(input int record_width, input int counter_width);
    return record_width + counter_width;
  endfunction

  function automatic int ts_lsb(input int record_width);
    return record_width;
  endfunction

endpackage

// File: rtl/gouram_trace_mux_if.sv
// Bundle of the per-channel trace inputs and the concentrated trace output stream.
interface gouram_trace_mux_if
  import gouram_trace_pkg::*;
#(
  parameter int NUM_CHANNELS  = 2,
  parameter int RECORD_WIDTH  = 128,
  parameter int COUNTER_WIDTH = 32,
  parameter int CH_IDX_W      = ch_idx_w(NUM_CHANNELS)
);
  logic [NUM_CHANNELS-1:0]              ch_valid_i;
  logic [NUM_CHANNELS*RECORD_WIDTH-1:0] ch_data_i;
  logic [NUM_CHANNELS-1:0]              ch_lock_o;
  logic                                 trace_valid_o;
  logic                                 trace_ready_i;
  logic [RECORD_WIDTH-1:0]              trace_data_o;
  logic [CH_IDX_W-1:0]                  trace_channel_o;
  logic [COUNTER_WIDTH-1:0]             trace_timestamp_o;
  logic [NUM_CHANNELS*DROP_CNT_W-1:0]   drop_count_o;
  logic [COUNTER_WIDTH-1:0]             counter_o;

  modport master (
    output ch_valid_i, ch_data_i, trace_ready_i,
    input  ch_lock_o, trace_valid_o, trace_data_o, trace_channel_o,
    input  trace_timestamp_o, drop_count_o, counter_o
  );

  modport slave (
    input  ch_valid_i, ch_data_i, trace_ready_i,
    output ch_lock_o, trace_valid_o, trace_data_o, trace_channel_o,
    output trace_timestamp_o, drop_count_o, counter_o
  );
endinterface

// File: rtl/gouram_trace_fifo.sv
// Single-clock FIFO holding timestamped trace entries for one channel.
// The caller only pushes when not full (or when popping in the same cycle) and only pops when not empty.
module gouram_trace_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Read/write pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == '0);
endmodule

// File: rtl/gouram_trace_mux.sv
// Multi-channel trace concentrator: timestamps records, buffers them per channel and
// drains them round-robin onto one valid/ready stream with drop accounting.
module gouram_trace_mux
  import gouram_trace_pkg::*;
#(
  parameter int NUM_CHANNELS  = 2,
  parameter int RECORD_WIDTH  = 128,
  parameter int FIFO_DEPTH    = 8,
  parameter int COUNTER_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  gouram_trace_mux_if.slave bus
);
  localparam int CH_IDX_W = ch_idx_w(NUM_CHANNELS);
  localparam int ENTRY_W  = entry_w(RECORD_WIDTH, COUNTER_WIDTH);
  localparam int TS_LSB   = ts_lsb(RECORD_WIDTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  logic [COUNTER_WIDTH-1:0] counter_r;
  logic [NUM_CHANNELS-1:0]  fifo_push_s;
  logic [NUM_CHANNELS-1:0]  fifo_pop_s;
  logic [NUM_CHANNELS-1:0]  fifo_full_s;
  logic [NUM_CHANNELS-1:0]  fifo_empty_s;
  logic [ENTRY_W-1:0]       fifo_dout_s [NUM_CHANNELS];

  out_state_e               state_r;
  out_state_e               state_s;
  logic [CH_IDX_W-1:0]      rr_ptr_r;
  logic [CH_IDX_W-1:0]      grant_s;
  logic [CH_IDX_W-1:0]      scan_idx_s;
  logic                     grant_vld_s;
  logic                     load_s;
  logic [ENTRY_W-1:0]       grant_entry_s;
  logic [RECORD_WIDTH-1:0]  out_data_r;
  logic [CH_IDX_W-1:0]      out_ch_r;
  logic [COUNTER_WIDTH-1:0] out_ts_r;

  // Free-running timestamp counter, wraps at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_r <= '0;
    end else begin
      counter_r <= counter_r + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0]      fifo_count_s;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign fifo_pop_s[g]  = load_s && (grant_s == CH_IDX_W'(g));
    assign fifo_push_s[g] = bus.ch_valid_i[g] && (!fifo_full_s[g] || fifo_pop_s[g]);

    gouram_trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push_s[g]),
      .pop   (fifo_pop_s[g]),
      .din   ({counter_r, bus.ch_data_i[g*RECORD_WIDTH +: RECORD_WIDTH]}),
      .dout  (fifo_dout_s[g]),
      .count (fifo_count_s),
      .full  (fifo_full_s[g]),
      .empty (fifo_empty_s[g])
    );

    // Saturating count of records refused because the channel FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        drop_cnt_r <= '0;
      end else if (bus.ch_valid_i[g] && !fifo_push_s[g] && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + 1'b1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end

    assign bus.ch_lock_o[g] = (fifo_count_s >= CNT_W'(FIFO_DEPTH - 1));
    assign bus.drop_count_o[g*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_r;
  end

  // Round-robin arbiter: first non-empty channel after the last granted one.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    scan_idx_s  = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      scan_idx_s = CH_IDX_W'((int'(rr_ptr_r) + k) % NUM_CHANNELS);
      if (!grant_vld_s && !fifo_empty_s[scan_idx_s]) begin
        grant_vld_s = 1'b1;
        grant_s     = scan_idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Select the head entry of the granted channel.
  always_comb begin
    grant_entry_s = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (grant_s == CH_IDX_W'(i)) begin
        grant_entry_s = fifo_dout_s[i];
      end else begin
        grant_entry_s = grant_entry_s;
      end
    end
  end

  // Output FSM next state; a load may overlap the handshake that frees the slot.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      OUT_EMPTY: begin
        if (grant_vld_s) begin
          load_s  = 1'b1;
          state_s = OUT_HOLD;
        end else begin
          state_s = OUT_EMPTY;
        end
      end
      OUT_HOLD: begin
        if (bus.trace_ready_i && grant_vld_s) begin
          load_s  = 1'b1;
          state_s = OUT_HOLD;
        end else if (bus.trace_ready_i) begin
          state_s = OUT_EMPTY;
        end else begin
          state_s = OUT_HOLD;
        end
      end
      default: begin
        state_s = OUT_EMPTY;
      end
    endcase
  end

  // Output state, arbitration pointer and held record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= OUT_EMPTY;
      rr_ptr_r   <= CH_IDX_W'(NUM_CHANNELS - 1);
      out_data_r <= '0;
      out_ch_r   <= '0;
      out_ts_r   <= '0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        rr_ptr_r   <= grant_s;
        out_data_r <= grant_entry_s[RECORD_WIDTH-1:0];
        out_ch_r   <= grant_s;
        out_ts_r   <= grant_entry_s[TS_LSB +: COUNTER_WIDTH];
      end else begin
        rr_ptr_r   <= rr_ptr_r;
        out_data_r <= out_data_r;
        out_ch_r   <= out_ch_r;
        out_ts_r   <= out_ts_r;
      end
    end
  end

  assign bus.trace_valid_o     = (state_r == OUT_HOLD);
  assign bus.trace_data_o      = out_data_r;
  assign bus.trace_channel_o   = out_ch_r;
  assign bus.trace_timestamp_o = out_ts_r;
  assign bus.counter_o         = counter_r;
endmodule

// File: tb/tb_gouram_trace_mux.sv
// Self-checking bench for gouram_trace_mux: directed tables and sequences plus random
// traffic compared against a queue-based reference model.
module tb_gouram_trace_mux;
  localparam int NCH   = 2;
  localparam int RW    = 128;
  localparam int DEPTH = 8;
  localparam int CW    = 8;

  typedef struct {
    int              ts;
    logic [RW-1:0]   data;
  } entry_t;

  typedef struct {
    logic [NCH-1:0]  v;
    logic [RW-1:0]   d0;
    logic [RW-1:0]   d1;
    logic            r;
    logic            ev;
    int              ech;
    logic [RW-1:0]   edata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gouram_trace_mux_if #(.NUM_CHANNELS(NCH), .RECORD_WIDTH(RW), .COUNTER_WIDTH(CW)) bus ();

  gouram_trace_mux #(
    .NUM_CHANNELS (NCH),
    .RECORD_WIDTH (RW),
    .FIFO_DEPTH   (DEPTH),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model state
  entry_t        mq [NCH][$];
  int            m_cnt;
  int            m_drop [NCH];
  bit            m_valid;
  logic [RW-1:0] m_data;
  int            m_ch;
  int            m_ts;
  int            m_ptr;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [RW-1:0] got, input logic [RW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mq[i].delete();
      m_drop[i] = 0;
    end
    m_cnt = 0; m_valid = 1'b0; m_data = '0; m_ch = 0; m_ts = 0; m_ptr = NCH - 1;
  endtask

  task automatic model_step(input logic [NCH-1:0] vv, input logic [RW-1:0] d0,
                            input logic [RW-1:0] d1, input logic r);
    logic [RW-1:0] dd [NCH];
    int g;
    entry_t e;
    dd[0] = d0; dd[1] = d1;
    g = -1;
    if (!m_valid || r) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
    end
    if (g >= 0) begin
      e = mq[g].pop_front();
      m_valid = 1'b1; m_data = e.data; m_ts = e.ts; m_ch = g; m_ptr = g;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (vv[i]) begin
        if (mq[i].size() < DEPTH) begin
          e.ts = m_cnt; e.data = dd[i];
          mq[i].push_back(e);
        end else if (m_drop[i] < 65535) begin
          m_drop[i]++;
        end
      end
    end
    m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  task automatic check_all();
    chk("valid", RW'(bus.trace_valid_o), RW'(m_valid));
    chk("data", bus.trace_data_o, m_data);
    chk("channel", RW'(bus.trace_channel_o), RW'(m_ch));
    chk("timestamp", RW'(bus.trace_timestamp_o), RW'(m_ts));
    chk("counter", RW'(bus.counter_o), RW'(m_cnt));
    for (int i = 0; i < NCH; i++) begin
      chk("lock", RW'(bus.ch_lock_o[i]), RW'(mq[i].size() >= DEPTH - 1));
      chk("drop", RW'(bus.drop_count_o[i*16 +: 16]), RW'(m_drop[i]));
    end
  endtask

  // Called at a falling edge: drive, clock, advance model, then check at the next falling edge.
  task automatic step(input logic [NCH-1:0] vv, input logic [RW-1:0] d0,
                      input logic [RW-1:0] d1, input logic r);
    bus.ch_valid_i    = vv;
    bus.ch_data_i     = {d1, d0};
    bus.trace_ready_i = r;
    @(posedge clk);
    model_step(vv, d0, d1, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    bus.ch_valid_i = '0; bus.ch_data_i = '0; bus.trace_ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    check_all();
  endtask

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // fairness table: both channels push for 4 cycles, ready held high
    for (int row = 0; row < 10; row++) begin
      tbl[row].v     = (row < 4) ? 2'b11 : 2'b00;
      tbl[row].d0    = RW'(8'h10 + row);
      tbl[row].d1    = RW'(8'h20 + row);
      tbl[row].r     = 1'b1;
      tbl[row].ev    = (row >= 1 && row <= 8);
      tbl[row].ech   = (row % 2 == 1) ? 0 : 1;
      tbl[row].edata = (row % 2 == 1) ? RW'(8'h10 + (row - 1) / 2) : RW'(8'h20 + (row - 2) / 2);
    end

    rst = 1'b1;
    do_reset();
    for (int row = 0; row < 10; row++) begin
      step(tbl[row].v, tbl[row].d0, tbl[row].d1, tbl[row].r);
      chk("tbl valid", RW'(bus.trace_valid_o), RW'(tbl[row].ev));
      if (tbl[row].ev) begin
        chk("tbl channel", RW'(bus.trace_channel_o), RW'(tbl[row].ech));
        chk("tbl data", bus.trace_data_o, tbl[row].edata);
      end
    end

    // latency and timestamp: pulse ch0 while counter_o=5
    do_reset();
    repeat (5) step(2'b00, '0, '0, 1'b1);
    step(2'b01, RW'(8'hA5), '0, 1'b1);
    chk("lat t+1 valid", RW'(bus.trace_valid_o), RW'(0));
    step(2'b00, '0, '0, 1'b1);
    chk("lat t+2 valid", RW'(bus.trace_valid_o), RW'(1));
    chk("lat data", bus.trace_data_o, RW'(8'hA5));
    chk("lat channel", RW'(bus.trace_channel_o), RW'(0));
    chk("lat ts", RW'(bus.trace_timestamp_o), RW'(5));
    step(2'b00, '0, '0, 1'b1);
    chk("lat t+3 valid", RW'(bus.trace_valid_o), RW'(0));

    // drop and lock with the consumer stalled
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(2'b01, RW'(8'hB0 + k), '0, 1'b0);
      chk("lock rise", RW'(bus.ch_lock_o[0]), RW'(k >= 7));
      if (k >= 1) chk("stall data", bus.trace_data_o, RW'(8'hB0));
    end
    chk("drop after 10", RW'(bus.drop_count_o[15:0]), RW'(1));

    // full FIFO with a same-cycle pop accepts the push
    step(2'b01, RW'(8'hC0), '0, 1'b1);
    chk("full pop drop", RW'(bus.drop_count_o[15:0]), RW'(1));
    chk("full pop data", bus.trace_data_o, RW'(8'hB1));
    chk("full pop lock", RW'(bus.ch_lock_o[0]), RW'(1));
    step(2'b01, RW'(8'hC1), '0, 1'b0);
    chk("still full drop", RW'(bus.drop_count_o[15:0]), RW'(2));

    // asynchronous reset between edges while holding a record
    #2 rst = 1'b1;
    #1;
    chk("arst valid", RW'(bus.trace_valid_o), RW'(0));
    chk("arst counter", RW'(bus.counter_o), RW'(0));
    chk("arst lock", RW'(bus.ch_lock_o), RW'(0));
    chk("arst drop", RW'(bus.drop_count_o), RW'(0));
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    check_all();
    step(2'b11, RW'(8'hD0), RW'(8'hD1), 1'b1);
    step(2'b00, '0, '0, 1'b1);
    chk("arst first grant", RW'(bus.trace_channel_o), RW'(0));
    chk("arst first data", bus.trace_data_o, RW'(8'hD0));

    // counter wrap: pushes at counter 255 and 0
    for (int n = 0; n < 300 && m_cnt != 255; n++) step(2'b00, '0, '0, 1'b1);
    chk("wrap reach", RW'(bus.counter_o), RW'(255));
    step(2'b01, RW'(8'hE0), '0, 1'b1);
    step(2'b01, RW'(8'hE1), '0, 1'b1);
    chk("wrap ts 255", RW'(bus.trace_timestamp_o), RW'(255));
    step(2'b00, '0, '0, 1'b1);
    chk("wrap ts 0", RW'(bus.trace_timestamp_o), RW'(0));
    chk("wrap data", bus.trace_data_o, RW'(8'hE1));

    // random traffic: slow consumer first, then mostly-ready
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [RW-1:0] r0, r1;
      logic rr;
      r0 = {$urandom, $urandom, $urandom, $urandom};
      r1 = {$urandom, $urandom, $urandom, $urandom};
      rr = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(NCH'($urandom), r0, r1, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
